// File: rtl/gold_fall_supervisor.sv
// rtl/gold_fall_supervisor.sv - per-bag fall query FSM plus collection/crush pulse logic
module gold_fall_supervisor #(
  parameter logic [10:0] BOARD_X    = 11'd32,
  parameter logic [10:0] BOARD_Y    = 11'd160,
  parameter logic [3:0]  BOARD_ROWS = 4'd10,
  parameter logic [7:0]  TIMEOUT    = 8'd64,
  parameter logic [9:0]  GOLD_SCORE = 10'd500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] goldTLX,
  input  logic [10:0] goldTLY,
  input  logic [3:0]  gold_state,
  input  logic        digger_hit,
  input  logic        dirt_ack,
  input  logic        dirt_empty,
  output logic        dirt_req,
  output logic [3:0]  dirt_col,
  output logic [3:0]  dirt_row,
  output logic        can_fall,
  output logic        been_eaten,
  output logic        score_valid,
  output logic [9:0]  score_value,
  output logic        digger_crushed,
  output logic        query_err
);

  localparam logic [3:0] ST_FALLING = 4'd2;
  localparam logic [3:0] ST_GONE    = 4'd3;
  localparam logic [3:0] ST_PILE    = 4'd4;

  typedef enum logic [1:0] {IDLE, CALC, REQ, DECIDE} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       result;
  logic       eaten_done;
  logic       hit_prev;
  logic       skip_query;
  logic       collect;
  logic       crush;

  // The cell under the bag is one row below its top-left corner; rows past the board bottom have no dirt.
  assign skip_query = (gold_state == ST_GONE) || (gold_state == ST_PILE) ||
                      (((goldTLY + 11'd32 - BOARD_Y) >> 5) >= 11'(BOARD_ROWS));
  assign collect    = digger_hit && (gold_state == ST_PILE) && !eaten_done;
  assign crush      = digger_hit && !hit_prev && (gold_state == ST_FALLING);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      result    <= 1'b0;
      dirt_req  <= 1'b0;
      dirt_col  <= 4'd0;
      dirt_row  <= 4'd0;
      can_fall  <= 1'b0;
      query_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (startOfFrame) state <= CALC;
        end
        CALC: begin
          dirt_col <= 4'((goldTLX - BOARD_X) >> 5);
          dirt_row <= 4'((goldTLY + 11'd32 - BOARD_Y) >> 5);
          cnt      <= 8'd0;
          if (skip_query) begin
            can_fall <= 1'b0;
            state    <= IDLE;
          end else begin
            dirt_req <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (dirt_ack) begin
            result   <= dirt_empty;
            dirt_req <= 1'b0;
            state    <= DECIDE;
          end else if (cnt == TIMEOUT - 8'd1) begin
            // An unanswered query is treated as solid ground so the bag never drops on a guess.
            result    <= 1'b0;
            query_err <= 1'b1;
            dirt_req  <= 1'b0;
            state     <= DECIDE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DECIDE: begin
          can_fall <= result;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eaten_done     <= 1'b0;
      hit_prev       <= 1'b0;
      been_eaten     <= 1'b0;
      score_valid    <= 1'b0;
      score_value    <= 10'd0;
      digger_crushed <= 1'b0;
    end else begin
      hit_prev       <= digger_hit;
      been_eaten     <= collect;
      score_valid    <= collect;
      score_value    <= collect ? GOLD_SCORE : 10'd0;
      digger_crushed <= crush;
      if (collect) eaten_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gold_fall_supervisor.sv
// tb/tb_gold_fall_supervisor.sv - scoreboard bench for gold_fall_supervisor
module tb_gold_fall_supervisor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startOfFrame = 1'b0;
  logic [10:0] goldTLX = 11'd0;
  logic [10:0] goldTLY = 11'd0;
  logic [3:0]  gold_state = 4'd0;
  logic        digger_hit = 1'b0;
  logic        dirt_ack = 1'b0;
  logic        dirt_empty = 1'b0;
  logic        dirt_req;
  logic [3:0]  dirt_col;
  logic [3:0]  dirt_row;
  logic        can_fall;
  logic        been_eaten;
  logic        score_valid;
  logic [9:0]  score_value;
  logic        digger_crushed;
  logic        query_err;

  gold_fall_supervisor dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .goldTLX(goldTLX), .goldTLY(goldTLY), .gold_state(gold_state),
    .digger_hit(digger_hit), .dirt_ack(dirt_ack), .dirt_empty(dirt_empty),
    .dirt_req(dirt_req), .dirt_col(dirt_col), .dirt_row(dirt_row),
    .can_fall(can_fall), .been_eaten(been_eaten), .score_valid(score_valid),
    .score_value(score_value), .digger_crushed(digger_crushed), .query_err(query_err)
  );

  always #5 clk = ~clk;

  localparam int EV_RISE  = 1;
  localparam int EV_FALL  = 2;
  localparam int EV_ERR   = 3;
  localparam int EV_CF    = 4;
  localparam int EV_EAT   = 5;
  localparam int EV_CRUSH = 6;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          q_kind[$];
  int          q_cyc[$];
  logic [15:0] q_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int kind, input int at, input logic [15:0] data);
    q_kind.push_back(kind);
    q_cyc.push_back(at);
    q_data.push_back(data);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [15:0] data);
    int          k;
    int          c;
    logic [15:0] d;
    checks++;
    if (q_kind.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind %0d data %h at cyc %0d, want none", kind, data, cyc);
    end else begin
      k = q_kind.pop_front();
      c = q_cyc.pop_front();
      d = q_data.pop_front();
      if (k != kind || c != cyc || d !== data) begin
        failures++;
        $display("FAIL event: got kind %0d cyc %0d data %h, want kind %0d cyc %0d data %h",
                 kind, cyc, data, k, c, d);
      end
    end
  endtask

  logic p_req = 1'b0;
  logic p_err = 1'b0;
  logic p_cf  = 1'b0;

  // Monitor: every observable output change is matched in order against the expectation queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (dirt_req && !p_req) expect_ev(EV_RISE, {8'd0, dirt_col, dirt_row});
      if (!dirt_req && p_req) expect_ev(EV_FALL, 16'd0);
      if (query_err && !p_err) expect_ev(EV_ERR, 16'd0);
      if (can_fall != p_cf) expect_ev(EV_CF, {15'd0, can_fall});
      if (been_eaten || score_valid || score_value != 10'd0)
        expect_ev(EV_EAT, {4'd0, been_eaten, score_valid, score_value});
      if (digger_crushed) expect_ev(EV_CRUSH, 16'd0);
    end
    p_req = reset ? 1'b0 : dirt_req;
    p_err = reset ? 1'b0 : query_err;
    p_cf  = reset ? 1'b0 : can_fall;
  end

  task automatic frame();
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
  endtask

  task automatic ack(input logic empty, input logic cf_changes);
    int k;
    k = cyc;
    push(EV_FALL, k + 1, 16'd0);
    if (cf_changes) push(EV_CF, k + 2, {15'd0, empty});
    dirt_ack   = 1'b1;
    dirt_empty = empty;
    tick(1);
    dirt_ack   = 1'b0;
    dirt_empty = 1'b0;
    tick(3);
  endtask

  initial begin
    int c;
    tick(3);
    check("reset_outputs",
          {8'd0, dirt_req, dirt_col, dirt_row, can_fall, been_eaten, score_valid, score_value, digger_crushed, query_err},
          32'd0);
    reset = 1'b0;
    tick(2);

    // Empty cell below: col 5, row 2, bag may fall
    goldTLX = 11'd192; goldTLY = 11'd192; gold_state = 4'd0;
    c = cyc;
    push(EV_RISE, c + 2, 16'h0052);
    frame();
    tick(2);
    ack(1'b1, 1'b1);

    // Solid cell answered after a long wait
    c = cyc;
    push(EV_RISE, c + 2, 16'h0052);
    frame();
    tick(10);
    check("req_held", {23'd0, dirt_req, dirt_col, dirt_row}, {23'd0, 1'b1, 4'd5, 4'd2});
    ack(1'b0, 1'b1);
    check("no_err_after_ack", {31'd0, query_err}, 32'd0);

    // No answer: abandon after 64 request clocks
    c = cyc;
    push(EV_RISE, c + 2, 16'h0052);
    push(EV_FALL, c + 66, 16'd0);
    push(EV_ERR, c + 66, 16'd0);
    frame();
    tick(70);
    check("timeout_err_cf", {30'd0, query_err, can_fall}, {30'd0, 1'b1, 1'b0});

    // Stray acks outside a request are ignored
    dirt_ack = 1'b1; dirt_empty = 1'b1;
    tick(3);
    dirt_ack = 1'b0; dirt_empty = 1'b0;
    tick(1);

    // Next frame after a timeout works normally; last valid row at left edge
    goldTLX = 11'd32; goldTLY = 11'd416;
    c = cyc;
    push(EV_RISE, c + 2, 16'h0009);
    frame();
    tick(2);
    ack(1'b1, 1'b1);
    check("err_sticky", {31'd0, query_err}, 32'd1);

    // Row 10 is below the board: no request, can_fall cleared
    goldTLY = 11'd448;
    c = cyc;
    push(EV_CF, c + 2, 16'd0);
    frame();
    tick(5);
    check("no_req_row10", {31'd0, dirt_req}, 32'd0);

    // Collection: single pulse for a held hit
    gold_state = 4'd4;
    c = cyc;
    push(EV_EAT, c + 1, {4'd0, 1'b1, 1'b1, 10'd500});
    digger_hit = 1'b1;
    tick(20);
    digger_hit = 1'b0;
    tick(2);

    // Gone bag: no pulses, no query
    gold_state = 4'd3;
    digger_hit = 1'b1;
    frame();
    tick(8);
    digger_hit = 1'b0;
    tick(2);

    // Crush on hit rising edge concurrent with frame start, then reset mid-request
    gold_state = 4'd2; goldTLX = 11'd192; goldTLY = 11'd192;
    c = cyc;
    push(EV_CRUSH, c + 1, 16'd0);
    push(EV_RISE, c + 2, 16'h0052);
    digger_hit   = 1'b1;
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    tick(3);
    check("in_req_before_reset", {31'd0, dirt_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("reset_mid_req",
          {8'd0, dirt_req, dirt_col, dirt_row, can_fall, been_eaten, score_valid, score_value, digger_crushed, query_err},
          32'd0);
    tick(2);
    digger_hit = 1'b0;
    reset = 1'b0;
    tick(4);

    check("queue_drained", q_kind.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
